// File: rtl/interboard_tx_queue.sv
// -----------------------------------------------------------------------------
// interboard_tx_queue
//
// Queues whole messages from GameControl and serialises them, one DATA_W-bit
// field per transfer, to the other board over a four-phase Request/Ack
// handshake. After reset the block drives an all-ones "reset beacon" with
// Request high for RST_HOLD cycles so the far board can resynchronise.
//
// Optional build macro: INTERBOARD_ACK_TIMEOUT_EN
//   Defined   -> each Ack edge is awaited for at most TIMEOUT cycles; on expiry
//                the current message is abandoned and timeout_err pulses.
//   Undefined -> the block waits for Ack indefinitely; timeout_err is 0.
//
// Ports:
//   clk, rst         system clock; synchronous active-high reset
//   ctrl_en          one-cycle enqueue strobe
//   ctrl_msg         packed message, field i = [i*DATA_W +: DATA_W]
//   ctrl_ready       a message offered this cycle will be accepted
//   overflow         one-cycle pulse: ctrl_en arrived while the FIFO was full
//   Ack              acknowledge from the other board (asynchronous)
//   Request          registered request to the other board
//   interboard_data  registered field data to the other board
//   busy             transfer in progress or messages queued
//   tx_done          one-cycle pulse after the last field's Ack falls
//   fifo_count       messages waiting in the FIFO
//   timeout_err      one-cycle pulse on an Ack timeout
// -----------------------------------------------------------------------------
module interboard_tx_queue #(
  parameter int DATA_W     = 6,
  parameter int NUM_FIELDS = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_HOLD   = 10,
  parameter int TIMEOUT    = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ctrl_en,
  input  logic [NUM_FIELDS*DATA_W-1:0]   ctrl_msg,
  output logic                           ctrl_ready,
  output logic                           overflow,
  input  logic                           Ack,
  output logic                           Request,
  output logic [DATA_W-1:0]              interboard_data,
  output logic                           busy,
  output logic                           tx_done,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           timeout_err
);

  localparam int MSG_W = NUM_FIELDS * DATA_W;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int IW    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int BW    = $clog2(RST_HOLD + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      NUM_FIELDS < 1 || RST_HOLD < 1 || TIMEOUT < 1) begin : g_param_check
    $error("interboard_tx_queue: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_BEACON,
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_WAIT_LOW
  } state_t;

  function automatic logic [DATA_W-1:0] field_of(input logic [MSG_W-1:0] msg,
                                                 input logic [IW-1:0]    i);
    return msg[int'(i) * DATA_W +: DATA_W];
  endfunction

  // Ack synchroniser: two flops before any use
  logic ack_p0, ack_p1, ack_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_p0 <= 1'b0;
      ack_p1 <= 1'b0;
    end else begin
      ack_p0 <= Ack;
      ack_p1 <= ack_p0;
    end
  end

  assign ack_s = ack_p1;

  // Message FIFO
  logic [MSG_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, empty, push, pop;
  logic [MSG_W-1:0] head;
  state_t           state, state_nxt;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign ctrl_ready = (state != S_BEACON) && (!full || pop);
  assign push       = ctrl_en && ctrl_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ctrl_msg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= ctrl_en && (state != S_BEACON) && !ctrl_ready;
    end
  end

  assign fifo_count = count;

  // Transfer FSM
  logic [MSG_W-1:0]  msg_hold;
  logic [IW-1:0]     idx, idx_nxt, idx_inc;
  logic [BW-1:0]     bcnt, bcnt_nxt;
  logic              req_nxt, done_nxt;
  logic [DATA_W-1:0] data_nxt;

  assign idx_inc = idx + 1'b1;

`ifdef INTERBOARD_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt, to_nxt;
  logic          terr_nxt, to_expired;

  assign to_expired = (to_cnt == TW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_nxt = state;
    req_nxt   = Request;
    data_nxt  = interboard_data;
    idx_nxt   = idx;
    bcnt_nxt  = bcnt;
    done_nxt  = 1'b0;
    pop       = 1'b0;
`ifdef INTERBOARD_ACK_TIMEOUT_EN
    to_nxt    = to_cnt;
    terr_nxt  = 1'b0;
`endif
    case (state)
      S_BEACON: begin
        if (bcnt == BW'(RST_HOLD - 1)) begin
          req_nxt   = 1'b0;
          data_nxt  = '0;
          state_nxt = S_IDLE;
        end else begin
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      S_IDLE: begin
        // Do not start while the far board still holds Ack from before.
        if (!empty && !ack_s) begin
          pop       = 1'b1;
          data_nxt  = head[DATA_W-1:0];
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        req_nxt   = 1'b1;
        state_nxt = S_REQ;
`ifdef INTERBOARD_ACK_TIMEOUT_EN
        to_nxt    = '0;
`endif
      end
      S_REQ: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = S_WAIT_LOW;
`ifdef INTERBOARD_ACK_TIMEOUT_EN
          to_nxt    = '0;
`endif
        end
`ifdef INTERBOARD_ACK_TIMEOUT_EN
        else if (to_expired) begin
          req_nxt   = 1'b0;
          idx_nxt   = '0;
          terr_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
`endif
      end
      S_WAIT_LOW: begin
        if (!ack_s) begin
          if (idx == IW'(NUM_FIELDS - 1)) begin
            idx_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            idx_nxt   = idx_inc;
            data_nxt  = field_of(msg_hold, idx_inc);
            state_nxt = S_SETUP;
          end
        end
`ifdef INTERBOARD_ACK_TIMEOUT_EN
        else if (to_expired) begin
          idx_nxt   = '0;
          terr_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = S_BEACON;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_BEACON;
      Request         <= 1'b1;
      interboard_data <= '1;
      idx             <= '0;
      bcnt            <= '0;
      tx_done         <= 1'b0;
    end else begin
      state           <= state_nxt;
      Request         <= req_nxt;
      interboard_data <= data_nxt;
      idx             <= idx_nxt;
      bcnt            <= bcnt_nxt;
      tx_done         <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) msg_hold <= head;
  end

`ifdef INTERBOARD_ACK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= to_nxt;
      timeout_err <= terr_nxt;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_interboard_tx_queue.sv
// -----------------------------------------------------------------------------
// tb_interboard_tx_queue
//
// Drives interboard_tx_queue with directed and randomised message traffic and
// an Ack responder that plays the far board. A transaction-level scoreboard
// (queue of accepted messages plus the index of the next expected field)
// predicts what must appear on the bus at every Request rise.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_interboard_tx_queue;

  localparam int DATA_W     = 6;
  localparam int NUM_FIELDS = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int RST_HOLD   = 10;
  localparam int TIMEOUT    = 20;
  localparam int MSG_W      = DATA_W * NUM_FIELDS;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ctrl_en = 1'b0;
  logic [MSG_W-1:0]  ctrl_msg = '0;
  logic              Ack = 1'b0;
  logic              ctrl_ready, overflow, Request, busy, tx_done, timeout_err;
  logic [DATA_W-1:0] interboard_data;
  logic [CW-1:0]     fifo_count;

  interboard_tx_queue #(
    .DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .FIFO_DEPTH(FIFO_DEPTH),
    .RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .ctrl_msg(ctrl_msg),
    .ctrl_ready(ctrl_ready), .overflow(overflow), .Ack(Ack),
    .Request(Request), .interboard_data(interboard_data), .busy(busy),
    .tx_done(tx_done), .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  logic [MSG_W-1:0] exp_q[$];
  int               fld = 0;
  bit               mon_en = 1'b0;
  bit               pend_ovf = 1'b0;
  logic             prev_req = 1'b1;
  logic [DATA_W-1:0] held_data = '0;
  int               tx_cnt = 0;
  int               to_seen = 0;
  bit               ack_hold = 1'b0;
  bit               rnd_dly = 1'b0;
  int               rsp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [MSG_W-1:0] m;
    for (int i = 0; i < NUM_FIELDS; i++) m[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 62));
    return m;
  endfunction

  // One clock: sample after the falling edge, score, then play the far board.
  task automatic tick();
    logic [MSG_W-1:0] cur;
    @(posedge clk);
    @(negedge clk);
    if (tx_done) tx_cnt++;
    if (timeout_err) to_seen++;
    if (mon_en) begin
      check("overflow", overflow, pend_ovf);
      if (Request && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("spurious_request", 1'b1, 1'b0);
        end else begin
          cur = exp_q[0];
          check("field_data", interboard_data, cur[fld*DATA_W +: DATA_W]);
          fld++;
        end
        held_data = interboard_data;
      end else if (Request && prev_req) begin
        check("data_stable", interboard_data, held_data);
      end
      if (tx_done) begin
        check("fields_at_done", fld, NUM_FIELDS);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        fld = 0;
      end
      if (timeout_err) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        fld = 0;
      end
`ifndef INTERBOARD_ACK_TIMEOUT_EN
      check("timeout_err_zero", timeout_err, 1'b0);
`endif
      check("busy", busy, exp_q.size() != 0);
      check("fifo_count_range",
            (int'(fifo_count) <= exp_q.size()) && (int'(fifo_count) + 1 >= exp_q.size()), 1'b1);
    end
    pend_ovf = 1'b0;
    if (Request != prev_req) rsp_cnt = rnd_dly ? int'($urandom_range(0, 4)) : 3;
    prev_req = Request;
    if (ack_hold) Ack = 1'b0;
    else if (Request != Ack) begin
      if (rsp_cnt == 0) Ack = Request;
      else rsp_cnt--;
    end
  endtask

  task automatic push(input logic [MSG_W-1:0] m, input bit exp_acc);
    ctrl_msg = m;
    ctrl_en  = 1'b1;
    if (exp_acc) exp_q.push_back(m);
    else pend_ovf = 1'b1;
    tick();
    ctrl_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    check("drain_complete", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [MSG_W-1:0] m;
    logic [MSG_W-1:0] qm[6];
    int t0, c;

    // Reset and beacon
    repeat (3) tick();
    check("rst_request", Request, 1'b1);
    check("rst_data", interboard_data, 6'h3F);
    check("rst_ctrl_ready", ctrl_ready, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= RST_HOLD; k++) begin
      tick();
      check("beacon_request", Request, k < RST_HOLD);
      check("beacon_data", interboard_data, (k < RST_HOLD) ? 64'h3F : 64'h0);
      check("beacon_ctrl_ready", ctrl_ready, k == RST_HOLD);
    end
    mon_en = 1'b1;
    repeat (6) tick();

    // Single message {1..6}, fixed 3-cycle responder
    for (int i = 0; i < NUM_FIELDS; i++) m[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    t0 = tx_cnt;
    push(m, 1'b1);
    check("lat_e0_request", Request, 1'b0);
    check("lat_e0_count", fifo_count, 1);
    tick();
    check("lat_e1_data", interboard_data, 1);
    check("lat_e1_request", Request, 1'b0);
    tick();
    check("lat_e2_request", Request, 1'b1);
    drain(600);
    check("single_tx_done_count", tx_cnt - t0, 1);
    check("single_fifo_empty", fifo_count, 0);

    // Queueing with Ack held low, then overflow
    ack_hold = 1'b1;
    for (int i = 0; i < 6; i++) qm[i] = rand_msg();
    push(qm[0], 1'b1);
    tick();
    for (int i = 1; i < 5; i++) push(qm[i], 1'b1);
    check("queue_full_count", fifo_count, 4);
    check("queue_full_ready", ctrl_ready, 1'b0);
    push(qm[5], 1'b0);
    check("overflow_pulse", overflow, 1'b1);
    check("overflow_count", fifo_count, 4);

    // Push coinciding with the IDLE pop at full
    ack_hold = 1'b0;
    t0 = tx_cnt;
    c = 0;
    while (tx_cnt == t0 && c < 500) begin
      tick();
      c++;
    end
    check("queue_first_done", tx_cnt - t0, 1);
    push(rand_msg(), 1'b1);
    check("simul_count", fifo_count, 4);
    check("simul_overflow", overflow, 1'b0);
    drain(3000);

    // Reset during field 3 with two messages queued
    for (int i = 0; i < 3; i++) push(rand_msg(), 1'b1);
    c = 0;
    while (fld < 4 && c < 300) begin
      tick();
      c++;
    end
    check("mid_reached_field3", fld, 4);
    check("mid_queued", fifo_count, 2);
    rst = 1'b1;
    exp_q.delete();
    fld = 0;
    mon_en = 1'b0;
    t0 = tx_cnt;
    repeat (2) tick();
    check("mid_rst_request", Request, 1'b1);
    check("mid_rst_count", fifo_count, 0);
    rst = 1'b0;
    repeat (RST_HOLD) tick();
    check("mid_no_tx_done", tx_cnt - t0, 0);
    check("mid_after_request", Request, 1'b0);
    check("mid_after_count", fifo_count, 0);
    check("mid_after_busy", busy, 1'b0);
    check("mid_after_ready", ctrl_ready, 1'b1);
    mon_en = 1'b1;
    repeat (6) tick();

    // Randomised traffic with random responder delays
    rnd_dly = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0 && exp_q.size() < FIFO_DEPTH) push(rand_msg(), 1'b1);
      else tick();
    end
    drain(3000);
    check("random_fifo_empty", fifo_count, 0);

`ifdef INTERBOARD_ACK_TIMEOUT_EN
    // Ack never rises: abandon first message, next one starts at field 0
    rnd_dly = 1'b0;
    repeat (6) tick();
    ack_hold = 1'b1;
    push(rand_msg(), 1'b1);
    push(rand_msg(), 1'b1);
    c = 0;
    while (!Request && c < 20) begin
      tick();
      c++;
    end
    check("to_request_rose", Request, 1'b1);
    t0 = to_seen;
    c = 0;
    while (to_seen == t0 && c < 100) begin
      tick();
      c++;
    end
    check("to_latency", c, TIMEOUT);
    check("to_request_low", Request, 1'b0);
    ack_hold = 1'b0;
    drain(600);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
